key_debounce_multi: RTL

//  Parametrised N-channel push-button conditioner for the game's key inputs (left/right/rotate/drop).
//  Per key it provides: 2-FF synchroniser, counter debounce, debounced level, press/release pulses,
//  and optional auto-repeat (typematic) while held. Sits between board pins and game control FSM.

---
 rtl/key_debounce_multi_if.sv | 21 ++
 rtl/key_debounce_multi.sv | 115 +++++++++++
 2 files changed

// File: rtl/key_debounce_multi_if.sv
// Key bundle between board pins / consumer and the multi-channel key conditioner.
interface key_debounce_multi_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] key_value;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_event;

    modport master (
        output key,
        input  key_value, key_press, key_release, key_repeat, key_event
    );

    modport slave (
        input  key,
        output key_value, key_press, key_release, key_repeat, key_event
    );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, counter debounce, press/release pulses
// and per-key auto-repeat while held.
module key_debounce_multi #(
    parameter int unsigned          NUM_KEYS       = 4,
    parameter int unsigned          DEBOUNCE_CYC   = 1_000_000,
    parameter int unsigned          REPEAT_DLY_CYC = 25_000_000,
    parameter int unsigned          REPEAT_PER_CYC = 5_000_000,
    parameter logic [NUM_KEYS-1:0]  REPEAT_EN_MASK = {NUM_KEYS{1'b1}},
    parameter int unsigned          CNT_W          = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_debounce_multi_if.slave kif
);

    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_e;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        logic             sync1_q, sync2_q, key_reg_q, value_q;
        logic             press_q, release_q, repeat_q;
        logic [CNT_W-1:0] cnt_q;
        logic             fire_c, press_c, release_c;

        rp_state_e        st_q, st_d;
        logic [CNT_W-1:0] rcnt_q, rcnt_d;
        logic             repeat_d;

        // A level is accepted only when the window expires on a real change.
        assign fire_c    = (cnt_q == CNT_W'(1)) && (key_reg_q != value_q);
        assign press_c   = fire_c && !key_reg_q;
        assign release_c = fire_c &&  key_reg_q;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                key_reg_q <= 1'b1;
                value_q   <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= kif.key[g];
                sync2_q   <= sync1_q;
                key_reg_q <= sync2_q;
                if (sync2_q != key_reg_q) begin
                    cnt_q <= CNT_W'(DEBOUNCE_CYC);
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                if (fire_c) begin
                    value_q <= key_reg_q;
                end
                press_q   <= press_c;
                release_q <= release_c;
            end
        end

        // Repeat FSM state register.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                st_q     <= RP_IDLE;
                rcnt_q   <= '0;
                repeat_q <= 1'b0;
            end else begin
                st_q     <= st_d;
                rcnt_q   <= rcnt_d;
                repeat_q <= repeat_d;
            end
        end

        // Repeat FSM next state; a release always wins over a due repeat tick.
        always_comb begin
            st_d     = st_q;
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            case (st_q)
                RP_IDLE: begin
                    if (press_c && REPEAT_EN_MASK[g]) begin
                        st_d   = RP_DELAY;
                        rcnt_d = CNT_W'(REPEAT_DLY_CYC);
                    end
                end
                RP_DELAY, RP_REPEAT: begin
                    if (release_c) begin
                        st_d   = RP_IDLE;
                        rcnt_d = '0;
                    end else if (rcnt_q == CNT_W'(1)) begin
                        st_d     = RP_REPEAT;
                        rcnt_d   = CNT_W'(REPEAT_PER_CYC);
                        repeat_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    st_d   = RP_IDLE;
                    rcnt_d = '0;
                end
            endcase
        end

        assign kif.key_value[g]   = value_q;
        assign kif.key_press[g]   = press_q;
        assign kif.key_release[g] = release_q;
        assign kif.key_repeat[g]  = repeat_q;
    end

    assign kif.key_event = kif.key_press | kif.key_repeat;

endmodule
